// File: rtl/gbuf_loader_if.sv
// Bundle between the host stream / A-B global buffer writes and the gbuf_loader.
// master = host/bench side, slave = the loader.
interface gbuf_loader_if #(
  parameter int WORD_SIZE = 32,
  parameter int ROW_SIZE  = 5
);
  logic                 start;
  logic [ROW_SIZE-1:0]  m;
  logic [ROW_SIZE-1:0]  n;
  logic                 s_valid;
  logic [WORD_SIZE-1:0] s_data;
  logic                 s_ready;
  logic                 wr_en_a;
  logic [ROW_SIZE-1:0]  idx_a;
  logic [WORD_SIZE-1:0] data_a;
  logic                 wr_en_b;
  logic [ROW_SIZE-1:0]  idx_b;
  logic [WORD_SIZE-1:0] data_b;
  logic                 busy;
  logic                 load_done;

  modport master (
    output start, m, n, s_valid, s_data,
    input  s_ready, wr_en_a, idx_a, data_a, wr_en_b, idx_b, data_b, busy, load_done
  );

  modport slave (
    input  start, m, n, s_valid, s_data,
    output s_ready, wr_en_a, idx_a, data_a, wr_en_b, idx_b, data_b, busy, load_done
  );
endinterface

// File: rtl/gbuf_loader.sv
// Fills GBUFF_A rows 0..m then GBUFF_B rows 0..n from a valid/ready word stream.
// Optional GBUF_LOADER_ZERO_PAD_EN: zero the unused rows of both buffers before load_done.
module gbuf_loader #(
  parameter int WORD_SIZE = 32,
  parameter int ROW_SIZE  = 5
) (
  input  logic               clk,
  input  logic               rst,
  gbuf_loader_if.slave       bus,
  output logic [2:0]         state_dbg
);

  // Handshake: a stream beat transfers on a rising edge where s_valid && s_ready;
  // s_ready depends only on the current state, never on s_valid.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
`ifdef GBUF_LOADER_ZERO_PAD_EN
    S_PAD    = 3'd3,
`endif
    S_FLUSH  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [ROW_SIZE:0] CNT_ONE = {{ROW_SIZE{1'b0}}, 1'b1};
`ifdef GBUF_LOADER_ZERO_PAD_EN
  localparam logic [ROW_SIZE:0] CNT_LAST = {1'b0, {ROW_SIZE{1'b1}}};
`endif

  state_t               state_q, state_d;
  // One bit wider than a row index so the last-row compare cannot alias.
  logic [ROW_SIZE:0]    cnt_q, cnt_d;
  logic [ROW_SIZE-1:0]  m_q, m_d, n_q, n_d;
  logic                 s_ready_c;
  logic                 accept;

  logic                 wr_en_a_q, wr_en_b_q;
  logic [ROW_SIZE-1:0]  idx_a_q, idx_b_q;
  logic [WORD_SIZE-1:0] data_a_q, data_b_q;
  logic                 busy_q, load_done_q;

  assign s_ready_c = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign accept    = s_ready_c && bus.s_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    n_d     = n_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          m_d     = bus.m;
          n_d     = bus.n;
          cnt_d   = '0;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (accept) begin
          if (cnt_q == {1'b0, m_q}) begin
            cnt_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_LOAD_B: begin
        if (accept) begin
          if (cnt_q == {1'b0, n_q}) begin
            cnt_d   = '0;
`ifdef GBUF_LOADER_ZERO_PAD_EN
            state_d = S_PAD;
`else
            state_d = S_FLUSH;
`endif
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
`ifdef GBUF_LOADER_ZERO_PAD_EN
      S_PAD: begin
        // Always sweeps every row, even when nothing needs zeroing.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FLUSH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      n_q     <= n_d;
    end
  end

  // Registered write ports: idx/data are forced to zero whenever the strobe is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_a_q   <= 1'b0;
      idx_a_q     <= '0;
      data_a_q    <= '0;
      wr_en_b_q   <= 1'b0;
      idx_b_q     <= '0;
      data_b_q    <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      wr_en_a_q <= 1'b0;
      idx_a_q   <= '0;
      data_a_q  <= '0;
      wr_en_b_q <= 1'b0;
      idx_b_q   <= '0;
      data_b_q  <= '0;
      if (state_q == S_LOAD_A && accept) begin
        wr_en_a_q <= 1'b1;
        idx_a_q   <= cnt_q[ROW_SIZE-1:0];
        data_a_q  <= bus.s_data;
      end
      if (state_q == S_LOAD_B && accept) begin
        wr_en_b_q <= 1'b1;
        idx_b_q   <= cnt_q[ROW_SIZE-1:0];
        data_b_q  <= bus.s_data;
      end
`ifdef GBUF_LOADER_ZERO_PAD_EN
      if (state_q == S_PAD) begin
        if (cnt_q > {1'b0, m_q}) begin
          wr_en_a_q <= 1'b1;
          idx_a_q   <= cnt_q[ROW_SIZE-1:0];
        end
        if (cnt_q > {1'b0, n_q}) begin
          wr_en_b_q <= 1'b1;
          idx_b_q   <= cnt_q[ROW_SIZE-1:0];
        end
      end
`endif
      // busy stays up through the cycle that carries load_done.
      busy_q      <= (state_q != S_IDLE) || bus.start;
      load_done_q <= (state_q == S_DONE);
    end
  end

  assign bus.s_ready   = s_ready_c;
  assign bus.wr_en_a   = wr_en_a_q;
  assign bus.idx_a     = idx_a_q;
  assign bus.data_a    = data_a_q;
  assign bus.wr_en_b   = wr_en_b_q;
  assign bus.idx_b     = idx_b_q;
  assign bus.data_b    = data_b_q;
  assign bus.busy      = busy_q;
  assign bus.load_done = load_done_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_gbuf_loader.sv
// Bench for gbuf_loader: random stream loads checked against a row-level write model.
module tb_gbuf_loader;
  localparam int WS  = 32;
  localparam int RS  = 5;
  localparam int E_W = 1 + RS + WS;
`ifdef GBUF_LOADER_ZERO_PAD_EN
  localparam int LAT = 35;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_dbg;

  gbuf_loader_if #(.WORD_SIZE(WS), .ROW_SIZE(RS)) bus ();

  gbuf_loader #(.WORD_SIZE(WS), .ROW_SIZE(RS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [WS-1:0]  beats[$];
  logic [E_W-1:0] exp_q[$];
  logic [E_W-1:0] obs_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt, done_cyc, first_busy, last_busy, last_acc, start_cyc, stray, bad_idle;
`ifndef GBUF_LOADER_ZERO_PAD_EN
  bit prev_acc = 1'b0;
`endif

  // Monitor: logs every buffer write as {buf, idx, data} and tracks timing marks.
  always @(negedge clk) begin
    if (bus.wr_en_a === 1'b1) obs_q.push_back({1'b0, bus.idx_a, bus.data_a});
    if (bus.wr_en_b === 1'b1) obs_q.push_back({1'b1, bus.idx_b, bus.data_b});
    if (bus.wr_en_a !== 1'b1 && (bus.idx_a !== '0 || bus.data_a !== '0)) bad_idle++;
    if (bus.wr_en_b !== 1'b1 && (bus.idx_b !== '0 || bus.data_b !== '0)) bad_idle++;
`ifndef GBUF_LOADER_ZERO_PAD_EN
    if ((bus.wr_en_a === 1'b1 || bus.wr_en_b === 1'b1) && !prev_acc) stray++;
    if (bus.wr_en_a === 1'b1 && bus.wr_en_b === 1'b1) stray++;
    prev_acc = (bus.s_valid === 1'b1 && bus.s_ready === 1'b1);
`endif
    if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) last_acc = cyc;
    if (bus.busy === 1'b1) begin
      if (first_busy < 0) first_busy = cyc;
      last_busy = cyc;
    end
    if (bus.load_done === 1'b1) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
  end

  // ---------------- reference model ----------------
  // A gets the first m+1 words, B the next n+1; padding zeros rows above m / n.
  task automatic build_exp(input int mm, input int nn);
    exp_q.delete();
    for (int i = 0; i <= mm; i++) exp_q.push_back({1'b0, i[RS-1:0], beats[i]});
    for (int j = 0; j <= nn; j++) exp_q.push_back({1'b1, j[RS-1:0], beats[mm + 1 + j]});
`ifdef GBUF_LOADER_ZERO_PAD_EN
    for (int k = 0; k < 32; k++) begin
      if (k > mm) exp_q.push_back({1'b0, k[RS-1:0], {WS{1'b0}}});
      if (k > nn) exp_q.push_back({1'b1, k[RS-1:0], {WS{1'b0}}});
    end
`endif
  endtask

  task automatic fill_beats(input int cnt, input bit ramp);
    beats.delete();
    for (int i = 0; i < cnt; i++) beats.push_back(ramp ? WS'(32'h10 + i) : WS'($urandom));
  endtask

  function automatic int first_diff();
    int lim;
    lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) if (obs_q[i] !== exp_q[i]) return i;
    if (obs_q.size() != exp_q.size()) return lim;
    return -1;
  endfunction

  function automatic logic [E_W-1:0] obs_at(input int i);
    return (i >= 0 && i < obs_q.size()) ? obs_q[i] : '0;
  endfunction

  function automatic logic [E_W-1:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : '0;
  endfunction

  // ---------------- driver ----------------
  // vmode: 0 = s_valid always high, 1 = toggling, 2 = random.
  task automatic run_load(input logic [RS-1:0] mm, input logic [RS-1:0] nn,
                          input int vmode, input bit poke_start);
    int idx, budget, total;
    total = int'(mm) + int'(nn) + 2;
    obs_q.delete();
    done_cnt = 0; done_cyc = -1; first_busy = -1; last_busy = -1;
    last_acc = -1; stray = 0; bad_idle = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.m = mm; bus.n = nn; start_cyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.m = RS'($urandom); bus.n = RS'($urandom);
    idx = 0; budget = 0;
    while (idx < total && budget < 2000) begin
      if (poke_start && idx == int'(mm) + 2) begin
        bus.start = 1'b1; bus.m = RS'($urandom); bus.n = RS'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      case (vmode)
        0:       bus.s_valid = 1'b1;
        1:       bus.s_valid = (budget % 2 == 0);
        default: bus.s_valid = 1'($urandom_range(0, 1));
      endcase
      bus.s_data = bus.s_valid ? beats[idx] : WS'($urandom);
      @(negedge clk);
      if (bus.s_valid && bus.s_ready === 1'b1) idx++;
      @(posedge clk); #1;
      budget++;
    end
    bus.s_valid = 1'b0; bus.start = 1'b0;
    budget = 0;
    while (done_cnt == 0 && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus.s_ready, bus.wr_en_a, bus.idx_a, bus.data_a, bus.wr_en_b, bus.idx_b,
         bus.data_b, bus.busy, bus.load_done} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ready=%b wa=%b wb=%b busy=%b done=%b, required all 0",
               bus.s_ready, bus.wr_en_a, bus.wr_en_b, bus.busy, bus.load_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int d;
    fill_beats(6, 1'b1);
    build_exp(3, 1);
    run_load(5'd3, 5'd1, 0, 1'b0);
    d = first_diff();
    tests_run++;
    if (d >= 0) begin
      tests_failed++;
      $display("FAIL basic_log: entry %0d got %h required %h (count %0d vs %0d)",
               d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
    end
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++; $display("FAIL basic_done_count: got %0d required 1", done_cnt);
    end
    tests_run++;
    if (done_cyc - last_acc !== LAT) begin
      tests_failed++; $display("FAIL basic_latency: got %0d required %0d", done_cyc - last_acc, LAT);
    end
    tests_run++;
    if (first_busy !== start_cyc + 1 || last_busy !== done_cyc) begin
      tests_failed++;
      $display("FAIL basic_busy_span: got %0d..%0d required %0d..%0d",
               first_busy, last_busy, start_cyc + 1, done_cyc);
    end
    tests_run++;
    if (stray !== 0 || bad_idle !== 0) begin
      tests_failed++; $display("FAIL basic_strobes: stray=%0d idle_nonzero=%0d required 0/0", stray, bad_idle);
    end
  endtask

  task automatic test_full();
    int d;
    fill_beats(64, 1'b0);
    build_exp(31, 31);
    run_load(5'd31, 5'd31, 0, 1'b0);
    d = first_diff();
    tests_run++;
    if (d >= 0) begin
      tests_failed++;
      $display("FAIL full_log: entry %0d got %h required %h (count %0d vs %0d)",
               d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
    end
    tests_run++;
    if (done_cnt !== 1 || done_cyc - last_acc !== LAT) begin
      tests_failed++;
      $display("FAIL full_done: got count %0d latency %0d required 1 / %0d", done_cnt, done_cyc - last_acc, LAT);
    end
    tests_run++;
    if (stray !== 0 || bad_idle !== 0) begin
      tests_failed++; $display("FAIL full_strobes: stray=%0d idle_nonzero=%0d required 0/0", stray, bad_idle);
    end
  endtask

  task automatic test_stall();
    int d;
    fill_beats(6, 1'b0);
    build_exp(2, 2);
    run_load(5'd2, 5'd2, 1, 1'b0);
    d = first_diff();
    tests_run++;
    if (d >= 0) begin
      tests_failed++;
      $display("FAIL stall_log: entry %0d got %h required %h (count %0d vs %0d)",
               d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
    end
    tests_run++;
    if (stray !== 0 || bad_idle !== 0) begin
      tests_failed++; $display("FAIL stall_strobes: stray=%0d idle_nonzero=%0d required 0/0", stray, bad_idle);
    end
    tests_run++;
    if (done_cnt !== 1 || done_cyc - last_acc !== LAT) begin
      tests_failed++;
      $display("FAIL stall_done: got count %0d latency %0d required 1 / %0d", done_cnt, done_cyc - last_acc, LAT);
    end
  endtask

  task automatic test_restart_ignored();
    int d;
    fill_beats(4 + 6, 1'b0);
    build_exp(3, 5);
    run_load(5'd3, 5'd5, 0, 1'b1);
    d = first_diff();
    tests_run++;
    if (d >= 0) begin
      tests_failed++;
      $display("FAIL restart_log: entry %0d got %h required %h (count %0d vs %0d)",
               d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
    end
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++; $display("FAIL restart_done_count: got %0d required 1", done_cnt);
    end
    tests_run++;
    if (last_busy !== done_cyc) begin
      tests_failed++; $display("FAIL restart_busy_end: got %0d required %0d", last_busy, done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int d;
    fill_beats(12, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.m = 5'd5; bus.n = 5'd5;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.s_valid = 1'b1; bus.s_data = beats[0];
    @(posedge clk); #1;
    bus.s_data = beats[1];
    @(posedge clk); #1;
    bus.s_valid = 1'b0; rst = 1'b1; done_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus.s_ready, bus.wr_en_a, bus.idx_a, bus.data_a, bus.wr_en_b, bus.idx_b,
         bus.data_b, bus.busy, bus.load_done} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got ready=%b wa=%b busy=%b done=%b, required all 0",
               bus.s_ready, bus.wr_en_a, bus.busy, bus.load_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = beats[2];
    repeat (50) @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    tests_run++;
    if (done_cnt !== 0 || bus.s_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_idle: got done_count %0d ready %b required 0 / 0", done_cnt, bus.s_ready);
    end
    build_exp(3, 4);
    run_load(5'd3, 5'd4, 0, 1'b0);
    d = first_diff();
    tests_run++;
    if (d >= 0) begin
      tests_failed++;
      $display("FAIL midreset_reload_log: entry %0d got %h required %h (count %0d vs %0d)",
               d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
    end
    tests_run++;
    if (done_cnt !== 1 || done_cyc - last_acc !== LAT) begin
      tests_failed++;
      $display("FAIL midreset_reload_done: got count %0d latency %0d required 1 / %0d",
               done_cnt, done_cyc - last_acc, LAT);
    end
  endtask

  task automatic test_pad_rows();
    int d;
    fill_beats(2 + 31, 1'b0);
    build_exp(1, 30);
    run_load(5'd1, 5'd30, 2, 1'b0);
    d = first_diff();
    tests_run++;
    if (d >= 0) begin
      tests_failed++;
      $display("FAIL pad_log: entry %0d got %h required %h (count %0d vs %0d)",
               d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
    end
    tests_run++;
    if (done_cnt !== 1 || done_cyc - last_acc !== LAT) begin
      tests_failed++;
      $display("FAIL pad_done: got count %0d latency %0d required 1 / %0d", done_cnt, done_cyc - last_acc, LAT);
    end
  endtask

  task automatic test_start_with_reset();
    int hits;
    hits = 0;
    @(posedge clk); #1;
    rst = 1'b1; bus.start = 1'b1; bus.m = 5'd3; bus.n = 5'd3;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.s_ready !== 1'b0) hits++;
    end
    tests_run++;
    if (hits !== 0) begin
      tests_failed++; $display("FAIL start_with_reset: got %0d busy/ready cycles required 0", hits);
    end
  endtask

  task automatic test_random();
    int d;
    logic [RS-1:0] mm, nn;
    for (int it = 0; it < 5; it++) begin
      mm = RS'($urandom_range(0, 31));
      nn = RS'($urandom_range(0, 31));
      fill_beats(int'(mm) + int'(nn) + 2, 1'b0);
      build_exp(int'(mm), int'(nn));
      run_load(mm, nn, 2, 1'b0);
      d = first_diff();
      tests_run++;
      if (d >= 0) begin
        tests_failed++;
        $display("FAIL random_log m=%0d n=%0d: entry %0d got %h required %h (count %0d vs %0d)",
                 mm, nn, d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
      end
      tests_run++;
      if (done_cnt !== 1 || done_cyc - last_acc !== LAT || last_busy !== done_cyc) begin
        tests_failed++;
        $display("FAIL random_done m=%0d n=%0d: got count %0d latency %0d busy_end %0d required 1 / %0d / %0d",
                 mm, nn, done_cnt, done_cyc - last_acc, last_busy, LAT, done_cyc);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.m = '0; bus.n = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    test_reset();
    test_basic();
    test_full();
    test_stall();
    test_restart_ignored();
    test_reset_mid();
    test_pad_rows();
    test_start_with_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
